// File: rtl/tb_alignment_collector.sv
// tb_alignment_collector: host-side receiver for the traceback alignment stream.
// Captures one op per alignment_valid cycle into a pack register (LSB-first).
// Full words are pushed into a small FIFO. On done, one final word (possibly
// empty) is pushed and marked last. Words drain over a valid/ready handshake.
//
// Ports:
//   clk, reset_i             clock, asynchronous active-high reset
//   tb_valid                 traceback enable; a rising edge starts an alignment
//   alignment_out/_valid     op code and its strobe
//   done                     single-cycle end-of-traceback pulse
//   word_o/_cnt_o/_last_o    FIFO head: packed ops, valid op count, last flag
//   word_valid_o/ready_i     host read handshake
//   busy_o                   collecting or flushing
//   overflow_o               sticky: a full word was dropped
//   total_ops_o              ops captured this alignment (saturating)
module tb_alignment_collector #(
    parameter int BP_WIDTH  = 2,
    parameter int PACK      = 16,
    parameter int CNT_WIDTH = 5,
    parameter int FIFO_AW   = 2
) (
    input  logic                     clk,
    input  logic                     reset_i,
    input  logic                     tb_valid,
    input  logic [BP_WIDTH-1:0]      alignment_out,
    input  logic                     alignment_valid,
    input  logic                     done,
    output logic [BP_WIDTH*PACK-1:0] word_o,
    output logic [CNT_WIDTH-1:0]     word_cnt_o,
    output logic                     word_last_o,
    output logic                     word_valid_o,
    input  logic                     word_ready_i,
    output logic                     busy_o,
    output logic                     overflow_o,
    output logic [15:0]              total_ops_o
);

    localparam int WordW = BP_WIDTH * PACK;
    localparam int Depth = 1 << FIFO_AW;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StFlush   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] FullCnt  = CNT_WIDTH'(PACK);
    localparam logic [CNT_WIDTH-1:0] LastSlot = CNT_WIDTH'(PACK - 1);
    localparam logic [FIFO_AW:0]     DepthCnt = (FIFO_AW + 1)'(Depth);

    logic [1:0]           state_q, state_d;
    logic                 tbv_prev_q;
    logic [WordW-1:0]     pack_q, pack_d;
    logic [CNT_WIDTH-1:0] fill_q, fill_d;
    logic [15:0]          total_q, total_d;
    logic                 ovf_q, ovf_d;

    logic [WordW-1:0]     mem_word_q [Depth];
    logic [CNT_WIDTH-1:0] mem_cnt_q  [Depth];
    logic                 mem_last_q [Depth];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;

    logic                 pop, full, push, push_last;
    logic [WordW-1:0]     push_word, slot_word;
    logic [CNT_WIDTH-1:0] push_cnt;

    assign pop  = (count_q != '0) && word_ready_i;
    assign full = (count_q == DepthCnt);

    always_comb begin
        state_d   = state_q;
        pack_d    = pack_q;
        fill_d    = fill_q;
        total_d   = total_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_word = pack_q;
        push_cnt  = fill_q;
        slot_word = pack_q;
        case (state_q)
            StIdle: begin
                if (tb_valid && !tbv_prev_q) begin
                    state_d = StCollect;
                    pack_d  = '0;
                    fill_d  = '0;
                    total_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            StCollect: begin
                if (alignment_valid) begin
                    slot_word[int'(fill_q)*BP_WIDTH +: BP_WIDTH] = alignment_out;
                    if (total_q != 16'hFFFF) total_d = total_q + 16'd1;
                    if (fill_q == LastSlot) begin
                        // Word complete: the slot register restarts empty whether or not
                        // the FIFO had room, so the next op always lands in slot 0.
                        fill_d    = '0;
                        pack_d    = '0;
                        push_word = slot_word;
                        push_cnt  = FullCnt;
                        if (full && !pop) ovf_d = 1'b1;
                        else              push  = 1'b1;
                    end else begin
                        fill_d = fill_q + 1'b1;
                        pack_d = slot_word;
                    end
                end
                // An op coinciding with done was captured above before flushing.
                if (done) state_d = StFlush;
            end
            StFlush: begin
                // The final word waits for space rather than being dropped. Unused
                // slots are already zero because pack_q is cleared on every restart.
                if (!full || pop) begin
                    push      = 1'b1;
                    push_last = 1'b1;
                    fill_d    = '0;
                    pack_d    = '0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            tbv_prev_q <= 1'b0;
            pack_q     <= '0;
            fill_q     <= '0;
            total_q    <= '0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tbv_prev_q <= tb_valid;
            pack_q     <= pack_d;
            fill_q     <= fill_d;
            total_q    <= total_d;
            ovf_q      <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word_q[wr_ptr_q] <= push_word;
            mem_cnt_q[wr_ptr_q]  <= push_cnt;
            mem_last_q[wr_ptr_q] <= push_last;
        end
    end

    assign word_valid_o = (count_q != '0);
    assign word_o       = word_valid_o ? mem_word_q[rd_ptr_q] : '0;
    assign word_cnt_o   = word_valid_o ? mem_cnt_q[rd_ptr_q] : '0;
    assign word_last_o  = word_valid_o ? mem_last_q[rd_ptr_q] : 1'b0;
    assign busy_o       = (state_q != StIdle);
    assign overflow_o   = ovf_q;
    assign total_ops_o  = total_q;

endmodule

// File: tb/tb_tb_alignment_collector.sv
// Bench for tb_alignment_collector: directed stimulus, a queue-based model of
// the expected word stream checked every cycle, and literal expectations.
module tb_tb_alignment_collector;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        tb_valid = 1'b0;
    logic [1:0]  aout = 2'd0;
    logic        av = 1'b0;
    logic        done = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] word_o;
    logic [4:0]  word_cnt_o;
    logic        word_last_o, word_valid_o, busy_o, overflow_o;
    logic [15:0] total_ops_o;

    always #5 clk = ~clk;

    tb_alignment_collector #(
        .BP_WIDTH (2),
        .PACK     (16),
        .CNT_WIDTH(5),
        .FIFO_AW  (2)
    ) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .tb_valid       (tb_valid),
        .alignment_out  (aout),
        .alignment_valid(av),
        .done           (done),
        .word_o         (word_o),
        .word_cnt_o     (word_cnt_o),
        .word_last_o    (word_last_o),
        .word_valid_o   (word_valid_o),
        .word_ready_i   (ready),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o),
        .total_ops_o    (total_ops_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] w;
        logic [4:0]  c;
        logic        l;
    } word_t;

    // Model: expected FIFO contents, pending ops of the current word, mode.
    word_t      mq[$];
    word_t      plog[$];
    logic [1:0] ops[$];
    int         m_mode;  // 0 idle, 1 collecting, 2 flushing
    bit         m_prev, m_ovf, m_pop, m_full, m_do_push;
    int         m_total;
    word_t      m_pw;

    function automatic word_t build(input bit last);
        word_t r;
        r.w = '0;
        foreach (ops[i]) r.w[i*2 +: 2] = ops[i];
        r.c = 5'(ops.size());
        r.l = last;
        return r;
    endfunction

    always @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            mq.delete();
            ops.delete();
            m_mode  = 0;
            m_prev  = 1'b0;
            m_total = 0;
            m_ovf   = 1'b0;
        end else begin
            m_pop     = (mq.size() > 0) && ready;
            m_full    = (mq.size() == 4);
            m_do_push = 1'b0;
            case (m_mode)
                0: if (tb_valid && !m_prev) begin
                    m_mode = 1;
                    ops.delete();
                    m_total = 0;
                    m_ovf   = 1'b0;
                end
                1: begin
                    if (av) begin
                        ops.push_back(aout);
                        if (m_total < 65535) m_total++;
                        if (ops.size() == 16) begin
                            m_pw = build(1'b0);
                            if (m_full && !m_pop) m_ovf = 1'b1;
                            else                  m_do_push = 1'b1;
                            ops.delete();
                        end
                    end
                    if (done) m_mode = 2;
                end
                default: if (!m_full || m_pop) begin
                    m_pw      = build(1'b1);
                    m_do_push = 1'b1;
                    ops.delete();
                    m_mode = 0;
                end
            endcase
            if (m_pop) void'(mq.pop_front());
            if (m_do_push) mq.push_back(m_pw);
            m_prev = tb_valid;
        end
    end

    // Per-cycle compare against the model, plus a log of words the host took.
    always @(negedge clk) begin
        chk("valid", {31'd0, word_valid_o}, {31'd0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("word", word_o, mq[0].w);
            chk("cnt", {27'd0, word_cnt_o}, {27'd0, mq[0].c});
            chk("last", {31'd0, word_last_o}, {31'd0, mq[0].l});
        end
        chk("busy", {31'd0, busy_o}, {31'd0, m_mode != 0});
        chk("overflow", {31'd0, overflow_o}, {31'd0, m_ovf});
        chk("total", {16'd0, total_ops_o}, 32'(m_total));
        if (word_valid_o && ready) plog.push_back({word_o, word_cnt_o, word_last_o});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input logic [1:0] c);
        av   = 1'b1;
        aout = c;
        tick();
        av = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        chk("rst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("rst_word", word_o, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_total", {16'd0, total_ops_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // 1: five ops then done, host stalled to inspect the head
        tb_valid = 1'b1;
        tick();
        chk("t1_busy_start", {31'd0, busy_o}, 32'd1);
        op(2'd0); op(2'd1); op(2'd2); op(2'd3); op(2'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("t1_busy_flush", {31'd0, busy_o}, 32'd1);
        tick();
        chk("t1_busy_end", {31'd0, busy_o}, 32'd0);
        chk("t1_valid", {31'd0, word_valid_o}, 32'd1);
        chk("t1_word", word_o, 32'h0000_00E4);
        chk("t1_cnt", {27'd0, word_cnt_o}, 32'd5);
        chk("t1_last", {31'd0, word_last_o}, 32'd1);
        chk("t1_total", {16'd0, total_ops_o}, 32'd5);
        ready    = 1'b1;
        tb_valid = 1'b0;
        tick();
        chk("t1_drained", {31'd0, word_valid_o}, 32'd0);

        // 2: 32 ops of code 2 with the host always ready
        plog.delete();
        tb_valid = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) op(2'd2);
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (4) tick();
        chk("t2_nwords", 32'(plog.size()), 32'd3);
        if (plog.size() == 3) begin
            chk("t2_w0", plog[0].w, 32'hAAAA_AAAA);
            chk("t2_c0", {27'd0, plog[0].c}, 32'd16);
            chk("t2_l0", {31'd0, plog[0].l}, 32'd0);
            chk("t2_w1", plog[1].w, 32'hAAAA_AAAA);
            chk("t2_c2", {27'd0, plog[2].c}, 32'd0);
            chk("t2_l2", {31'd0, plog[2].l}, 32'd1);
            chk("t2_w2", plog[2].w, 32'd0);
        end

        // 3: host stalled, 6 full words -> 2 dropped, flush stalls
        ready    = 1'b0;
        tb_valid = 1'b0;
        tick();
        tb_valid = 1'b1;
        tick();
        plog.delete();
        for (int i = 0; i < 96; i++) op(2'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (3) tick();
        chk("t3_busy_stall", {31'd0, busy_o}, 32'd1);
        chk("t3_ovf", {31'd0, overflow_o}, 32'd1);
        chk("t3_total", {16'd0, total_ops_o}, 32'd96);
        ready = 1'b1;
        repeat (8) tick();
        chk("t3_nwords", 32'(plog.size()), 32'd5);
        chk("t3_busy_end", {31'd0, busy_o}, 32'd0);
        if (plog.size() == 5) begin
            chk("t3_w0", plog[0].w, 32'h5555_5555);
            chk("t3_c0", {27'd0, plog[0].c}, 32'd16);
            chk("t3_c4", {27'd0, plog[4].c}, 32'd0);
            chk("t3_l4", {31'd0, plog[4].l}, 32'd1);
        end

        // 4: 16th op coincides with done
        tb_valid = 1'b0;
        tick();
        tb_valid = 1'b1;
        tick();
        plog.delete();
        for (int i = 0; i < 15; i++) op(2'd3);
        av   = 1'b1;
        aout = 2'd3;
        done = 1'b1;
        tick();
        av   = 1'b0;
        done = 1'b0;
        repeat (4) tick();
        chk("t4_nwords", 32'(plog.size()), 32'd2);
        if (plog.size() == 2) begin
            chk("t4_w0", plog[0].w, 32'hFFFF_FFFF);
            chk("t4_c0", {27'd0, plog[0].c}, 32'd16);
            chk("t4_l0", {31'd0, plog[0].l}, 32'd0);
            chk("t4_c1", {27'd0, plog[1].c}, 32'd0);
            chk("t4_l1", {31'd0, plog[1].l}, 32'd1);
        end

        // 5: reset mid-collect with 3 words buffered, then a fresh alignment
        ready    = 1'b0;
        tb_valid = 1'b0;
        tick();
        tb_valid = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) op(2'd2);
        chk("t5_buffered", {31'd0, word_valid_o}, 32'd1);
        reset_i = 1'b1;
        #1;
        chk("t5_rst_valid", {31'd0, word_valid_o}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_rst_total", {16'd0, total_ops_o}, 32'd0);
        tick();
        reset_i = 1'b0;
        tick();
        tb_valid = 1'b0;
        tick();
        tb_valid = 1'b1;
        tick();
        chk("t5_restart", {31'd0, busy_o}, 32'd1);
        op(2'd1); op(2'd2); op(2'd3);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t5_word", word_o, 32'h0000_0039);
        chk("t5_cnt", {27'd0, word_cnt_o}, 32'd3);
        chk("t5_last", {31'd0, word_last_o}, 32'd1);
        chk("t5_total", {16'd0, total_ops_o}, 32'd3);
        ready = 1'b1;
        tick();

        // 6: ops while idle with tb_valid still high are ignored
        av   = 1'b1;
        aout = 2'd2;
        repeat (3) tick();
        av   = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("t6_total", {16'd0, total_ops_o}, 32'd3);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_valid", {31'd0, word_valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_alignment_collector.md
# tb_alignment_collector

Host-side receiver for the traceback alignment stream. Captures one alignment op per `alignment_valid` cycle, packs ops LSB-first into host words, and terminates each traceback with a final word on `done`. Buffers words in a small FIFO and drains them over a valid/ready handshake. Sits between the traceback engine outputs (`alignment_out`, `alignment_valid`, `done`, `tb_valid`) and the host read port.

## Interface
- `BP_WIDTH`, 2, bits per alignment op (matches `` `BP_WIDTH``)
- `PACK`, 16, ops per host word; power of two, ≥2
- `CNT_WIDTH`, 5, log2(PACK)+1
- `FIFO_AW`, 2, FIFO address bits; depth = 2**FIFO_AW
- `clk` in 1, single clock, rising edge
- `reset_i` in 1, asynchronous, active-high reset
- `tb_valid` in 1, traceback enable from DP; rising edge starts a new alignment
- `alignment_out` in BP_WIDTH, op code from traceback
- `alignment_valid` in 1, `alignment_out` valid this cycle
- `done` in 1, single-cycle pulse: traceback finished
- `word_o` out BP_WIDTH*PACK, packed ops; op k in bits [k*BP_WIDTH +: BP_WIDTH]
- `word_cnt_o` out CNT_WIDTH, valid ops in `word_o` (0..PACK)
- `word_last_o` out 1, final word of the current alignment
- `word_valid_o` out 1, FIFO head valid
- `word_ready_i` in 1, host accepts head word
- `busy_o` out 1, collector in COLLECT or FLUSH
- `overflow_o` out 1, sticky: a full word was dropped
- `total_ops_o` out 16, ops captured this alignment, saturating at 0xFFFF

## Operation
- States: IDLE, COLLECT, FLUSH. Reset → IDLE.
- IDLE: `alignment_valid`/`done` ignored. `tb_valid` rising edge (previous-cycle sample 0, current 1) → COLLECT; same edge clears the pack register, fill counter, `total_ops_o` and `overflow_o`.
- COLLECT: each `alignment_valid` cycle writes `alignment_out` into slot `fill` and increments `fill` and `total_ops_o` (saturating).
- When an accepted op makes fill == PACK, the word is pushed with cnt=PACK, last=0, and `fill` returns to 0 that same cycle.
- If the FIFO is full and not popping at that push, the word is discarded, `overflow_o` is set, and `fill` still returns to 0.
- `done` in COLLECT → FLUSH. An op on the same cycle as `done` is captured first, including any full-word push it triggers.
- FLUSH: push one word with cnt=`fill` (may be 0), last=1, and unused slots zero. Stay in FLUSH while the FIFO is full and not popping; the final word is never dropped. After the push, clear `fill` → IDLE.
- Ops arriving in FLUSH are ignored.
- A `tb_valid` rising edge outside IDLE is ignored.
- FIFO: pop when `word_valid_o && word_ready_i`. Simultaneous push and pop when full: both take effect. Occupancy never exceeds 2**FIFO_AW.
- `word_o`/`word_cnt_o`/`word_last_o` are the FIFO head, held stable while `word_valid_o && !word_ready_i`.

## Timing
- Reset values: `word_valid_o`=0, `word_o`=0, `word_cnt_o`=0, `word_last_o`=0, `busy_o`=0, `overflow_o`=0, `total_ops_o`=0; FIFO empty. Asserting `reset_i` mid-traceback discards all buffered and partial data immediately.
- Start latency: `tb_valid` rise at edge N → `busy_o`=1 after edge N; an op presented in cycle N+1 is captured.
- Push latency: word pushed at edge N → `word_valid_o`=1 after edge N when the FIFO was empty.
- `done` sampled at edge N → FLUSH after N; final word pushed at edge N+1 if space exists → `busy_o`=0 after N+1.
- Throughput: one op per cycle sustained; one word popped per cycle.

## Test plan
- Reset, `tb_valid` rise, 5 ops (0,1,2,3,0), `done` → one word: `word_o`=0x0000_00E4, cnt=5, last=1, `total_ops_o`=5, `busy_o` falls 2 cycles after `done`.
- 32 ops of code 2 with `word_ready_i`=1, then `done` → words 0xAAAA_AAAA cnt=16 last=0 (×2), then cnt=0 last=1.
- `word_ready_i`=0, 6×16 ops, `done` → 4 words buffered, 5th and 6th full words dropped, `overflow_o`=1. FLUSH stalls until `word_ready_i`=1. Then 5 words drain, the last with cnt=0 and last=1.
- 16th op and `done` in the same cycle → full word (last=0) followed by cnt=0 last=1 word.
- `reset_i` pulse mid-COLLECT with 3 words buffered → next cycle `word_valid_o`=0, `busy_o`=0, `total_ops_o`=0. New `tb_valid` rise works normally.
- `alignment_valid` pulses while IDLE and `tb_valid` held high across a second alignment without a fall → no capture, `total_ops_o` unchanged.
